// File: rtl/rgb_window_3x3.sv
// Streaming 3x3 RGB window generator with two line buffers.
// Define WINDOW_OUT_REG_EN for an extra output register stage.
module rgb_window_3x3 #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] pixel_in,
  input  logic        pixel_in_valid,
  output logic [23:0] input_pixel_1,
  output logic [23:0] input_pixel_2,
  output logic [23:0] input_pixel_3,
  output logic [23:0] input_pixel_4,
  output logic [23:0] input_pixel_5,
  output logic [23:0] input_pixel_6,
  output logic [23:0] input_pixel_7,
  output logic [23:0] input_pixel_8,
  output logic [23:0] input_pixel_9,
  output logic        window_valid,
  output logic        frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          col_last;
  logic          row_last;
  logic          win_hit;
  logic          accept;

  logic [23:0]   lb1 [IMG_WIDTH];
  logic [23:0]   lb2 [IMG_WIDTH];
  logic [23:0]   lb1_rd;
  logic [23:0]   lb2_rd;

  logic [23:0]   win [9];
  logic          win_valid;
  logic          win_done;

  assign accept   = pixel_in_valid;
  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);
  assign win_hit  = (row >= RW'(2)) && (col >= CW'(2));

  assign lb1_rd = lb1[col];
  assign lb2_rd = lb2[col];

  // Buffers are deliberately not reset; a dropped pixel under rst
  // must not disturb them either.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      lb2[col] <= lb1_rd;
      lb1[col] <= pixel_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) begin
        win[i] <= '0;
      end
      win_valid <= 1'b0;
      win_done  <= 1'b0;
    end else begin
      win_valid <= accept && win_hit;
      win_done  <= accept && win_hit && row_last && col_last;
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          win[3*r]   <= win[3*r+1];
          win[3*r+1] <= win[3*r+2];
        end
        win[2] <= lb2_rd;
        win[5] <= lb1_rd;
        win[8] <= pixel_in;
      end
    end
  end

`ifdef WINDOW_OUT_REG_EN
  logic [23:0] win_q [9];
  logic        win_valid_q;
  logic        win_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
      win_valid_q <= 1'b0;
      win_done_q  <= 1'b0;
    end else begin
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= win[i];
      end
      win_valid_q <= win_valid;
      win_done_q  <= win_done;
    end
  end

  assign input_pixel_1 = win_q[0];
  assign input_pixel_2 = win_q[1];
  assign input_pixel_3 = win_q[2];
  assign input_pixel_4 = win_q[3];
  assign input_pixel_5 = win_q[4];
  assign input_pixel_6 = win_q[5];
  assign input_pixel_7 = win_q[6];
  assign input_pixel_8 = win_q[7];
  assign input_pixel_9 = win_q[8];
  assign window_valid  = win_valid_q;
  assign frame_done    = win_done_q;
`else
  assign input_pixel_1 = win[0];
  assign input_pixel_2 = win[1];
  assign input_pixel_3 = win[2];
  assign input_pixel_4 = win[3];
  assign input_pixel_5 = win[4];
  assign input_pixel_6 = win[5];
  assign input_pixel_7 = win[6];
  assign input_pixel_8 = win[7];
  assign input_pixel_9 = win[8];
  assign window_valid  = win_valid;
  assign frame_done    = win_done;
`endif

endmodule

// File: tb/tb_rgb_window_3x3.sv
// Scoreboard bench for rgb_window_3x3 on an 8x6 frame.
// Honours WINDOW_OUT_REG_EN for the expected latency.
module tb_rgb_window_3x3;

  localparam int W = 8;
  localparam int H = 6;
`ifdef WINDOW_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] pixel_in = '0;
  logic        pixel_in_valid = 1'b0;
  logic [23:0] input_pixel_1, input_pixel_2, input_pixel_3;
  logic [23:0] input_pixel_4, input_pixel_5, input_pixel_6;
  logic [23:0] input_pixel_7, input_pixel_8, input_pixel_9;
  logic        window_valid;
  logic        frame_done;
  logic [8:0][23:0] got;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = 0;

  typedef struct {
    int               due;
    logic [8:0][23:0] taps;
    logic             fd;
  } exp_t;

  exp_t q[$];

  rgb_window_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk),
    .rst(rst),
    .pixel_in(pixel_in),
    .pixel_in_valid(pixel_in_valid),
    .input_pixel_1(input_pixel_1),
    .input_pixel_2(input_pixel_2),
    .input_pixel_3(input_pixel_3),
    .input_pixel_4(input_pixel_4),
    .input_pixel_5(input_pixel_5),
    .input_pixel_6(input_pixel_6),
    .input_pixel_7(input_pixel_7),
    .input_pixel_8(input_pixel_8),
    .input_pixel_9(input_pixel_9),
    .window_valid(window_valid),
    .frame_done(frame_done)
  );

  assign got = {input_pixel_9, input_pixel_8, input_pixel_7,
                input_pixel_6, input_pixel_5, input_pixel_4,
                input_pixel_3, input_pixel_2, input_pixel_1};

  always #5 clk = ~clk;

  function automatic logic [23:0] pix(input logic [7:0] off,
                                      input int r, input int c);
    return {8'(r) + off, 8'(c), 8'hA5};
  endfunction

  task automatic run_stream(input int nframes, input int npix,
                            input int gap_pct, input logic [7:0] off0,
                            input logic [7:0] step,
                            output int nwin, output int nfd,
                            output logic [8:0][23:0] first_got);
    int r = 0;
    int c = 0;
    int f = 0;
    int sent = 0;
    int idle = 0;
    logic v;
    logic [7:0] off;
    exp_t e;
    nwin = 0;
    nfd = 0;
    first_got = '0;
    while (idle < LAT + 3) begin
      v = (sent < npix) && ($urandom_range(0, 99) >= gap_pct);
      off = off0 + 8'(f) * step;
      pixel_in = v ? pix(off, r, c) : 24'($urandom);
      pixel_in_valid = v;
      @(posedge clk);
      edge_n++;
      if (v) begin
        if (r >= 2 && c >= 2) begin
          e.due = edge_n + LAT - 1;
          for (int k = 0; k < 9; k++)
            e.taps[k] = pix(off, r - 2 + k / 3, c - 2 + k % 3);
          e.fd = (r == H - 1) && (c == W - 1);
          q.push_back(e);
        end
        sent++;
        c++;
        if (c == W) begin
          c = 0;
          r++;
          if (r == H) begin
            r = 0;
            f++;
          end
        end
      end else if (sent >= npix) begin
        idle++;
      end
      #1;
      if (window_valid) begin
        n_checks++;
        if (q.size() == 0 || q[0].due != edge_n) begin
          $display("FAIL unexpected_pulse edge=%0d got=%h", edge_n, got);
        end else begin
          e = q.pop_front();
          if (nwin == 0) first_got = got;
          nwin++;
          if (frame_done) nfd++;
          if (got !== e.taps || frame_done !== e.fd)
            $display("FAIL window edge=%0d got=%h fd=%b exp=%h fd=%b",
                     edge_n, got, frame_done, e.taps, e.fd);
          else
            n_pass++;
        end
      end else begin
        if (frame_done) begin
          n_checks++;
          $display("FAIL lone_frame_done edge=%0d got=1 exp=0", edge_n);
        end
        if (q.size() > 0 && q[0].due == edge_n) begin
          n_checks++;
          $display("FAIL missing_window edge=%0d got=0 exp=%h",
                   edge_n, q[0].taps);
          void'(q.pop_front());
        end
      end
    end
    pixel_in_valid = 1'b0;
    n_checks++;
    if (q.size() != 0) begin
      $display("FAIL leftover_windows got=%0d exp=0", q.size());
      q.delete();
    end else begin
      n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pixel_in = 24'($urandom);
      pixel_in_valid = 1'($urandom);
      @(posedge clk);
      edge_n++;
      #1;
      n_checks++;
      if (got !== '0 || window_valid !== 1'b0 || frame_done !== 1'b0)
        $display("FAIL reset_state got=%h wv=%b fd=%b exp=0",
                 got, window_valid, frame_done);
      else
        n_pass++;
    end
    rst = 1'b0;
    pixel_in_valid = 1'b0;
  endtask

  task automatic test_full_frame();
    int nw, nf;
    logic [8:0][23:0] fg;
    run_stream(1, W * H, 0, 8'h00, 8'h00, nw, nf, fg);
    n_checks++;
    if (nw !== 24) $display("FAIL full_count got=%0d exp=24", nw);
    else n_pass++;
    n_checks++;
    if (nf !== 1) $display("FAIL full_frame_done got=%0d exp=1", nf);
    else n_pass++;
    n_checks++;
    if (fg[0] !== 24'h0000A5 || fg[4] !== 24'h0101A5 ||
        fg[8] !== 24'h0202A5)
      $display("FAIL first_window got=%h/%h/%h exp=0000a5/0101a5/0202a5",
               fg[0], fg[4], fg[8]);
    else
      n_pass++;
  endtask

  task automatic test_gaps();
    int nw, nf;
    logic [8:0][23:0] fg;
    run_stream(1, W * H, 40, 8'h00, 8'h00, nw, nf, fg);
    n_checks++;
    if (nw !== 24) $display("FAIL gap_count got=%0d exp=24", nw);
    else n_pass++;
    n_checks++;
    if (nf !== 1) $display("FAIL gap_frame_done got=%0d exp=1", nf);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int nw, nf;
    logic [8:0][23:0] fg;
    run_stream(2, 2 * W * H, 0, 8'h00, 8'h10, nw, nf, fg);
    n_checks++;
    if (nw !== 48) $display("FAIL b2b_count got=%0d exp=48", nw);
    else n_pass++;
    n_checks++;
    if (nf !== 2) $display("FAIL b2b_frame_done got=%0d exp=2", nf);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int nw, nf;
    logic [8:0][23:0] fg;
    run_stream(1, 20, 0, 8'h40, 8'h00, nw, nf, fg);
    n_checks++;
    if (nw !== 2) $display("FAIL abort_count got=%0d exp=2", nw);
    else n_pass++;
    rst = 1'b1;
    pixel_in = pix(8'h40, 2, 4);
    pixel_in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      edge_n++;
      #1;
      n_checks++;
      if (got !== '0 || window_valid !== 1'b0 || frame_done !== 1'b0)
        $display("FAIL mid_reset_state got=%h wv=%b fd=%b exp=0",
                 got, window_valid, frame_done);
      else
        n_pass++;
    end
    rst = 1'b0;
    pixel_in_valid = 1'b0;
    run_stream(1, W * H, 20, 8'h20, 8'h00, nw, nf, fg);
    n_checks++;
    if (nw !== 24) $display("FAIL post_reset_count got=%0d exp=24", nw);
    else n_pass++;
    n_checks++;
    if (nf !== 1) $display("FAIL post_reset_frame_done got=%0d exp=1", nf);
    else n_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_full_frame();
    test_gaps();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rgb_window_3x3.md
# rgb_window_3x3

Streaming 3x3 window generator for 24-bit RGB raster video. Accepts one pixel per qualified cycle in raster order and buffers the two previous rows in on-chip line buffers. For every interior centre pixel, it presents the full 3x3 neighbourhood as nine parallel 24-bit taps. It sits upstream of the per-channel edge-detection stage and supplies its eight neighbour inputs, plus the centre tap for downstream filtering.

## Interface
- IMG_WIDTH, 512, pixels per row; must be >= 3.
- IMG_HEIGHT, 512, rows per frame; must be >= 3.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- pixel_in  input  24  RGB pixel, {R[23:16], G[15:8], B[7:0]}.
- pixel_in_valid  input  1  qualifies pixel_in; no backpressure, every valid pixel is accepted.
- input_pixel_1 .. input_pixel_9  output  24 each  window taps in row-major order:
  - 1/2/3 = top row (left, centre, right).
  - 4/5/6 = middle row.
  - 7/8/9 = bottom row.
  - 5 = centre.
- window_valid  output  1  one-cycle pulse; taps hold a new valid window.
- frame_done  output  1  one-cycle pulse coincident with the last window of a frame.

## Operation
- Counters:
  - col counts 0..IMG_WIDTH-1 and row counts 0..IMG_HEIGHT-1, both sized $clog2 of their limit.
  - Both advance only on accepted pixels (pixel_in_valid=1).
  - col wraps to 0 and increments row. After (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0 for the next frame.
- Line buffers:
  - lb1 holds row-1 and lb2 holds row-2, each IMG_WIDTH x 24 bits, indexed by col.
  - On accept: read lb2[col] and lb1[col], write lb2[col] <= lb1[col] and lb1[col] <= pixel_in (read-before-write, same cycle).
- Window shift register: 3x3 registers. On accept, every row shifts left one column, and the new right column = {lb2[col], lb1[col], pixel_in} (top, middle, bottom).
- Validity:
  - Window is valid when the accepted pixel has row >= 2 and col >= 2.
  - Centre is then (row-1, col-1); input_pixel_1 = (row-2, col-2) and input_pixel_9 = (row, col).
  - Stale columns carried across a row boundary only occur while col < 2, so they are never flagged valid.
- Windows per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2). Border centres produce no window.
- Input gaps (pixel_in_valid=0): counters, buffers and taps hold, and window_valid/frame_done are 0.
- frame_done asserts with the window whose accepting pixel is (IMG_HEIGHT-1, IMG_WIDTH-1).
- Line buffer contents are not reset. The first two rows of each frame are never used in a valid window, so contents carried over between frames are harmless.

## Timing
- Reset values:
  - col=0, row=0.
  - All nine taps = 24'h0.
  - window_valid=0, frame_done=0.
- Latency: taps, window_valid and frame_done update at the same rising edge that accepts the pixel, so they are visible the following cycle (1 cycle).
- Throughput: one window per clock when pixel_in_valid is held high.
- Reset mid-frame: takes effect at the next edge. The next accepted pixel is treated as (0,0), and no window_valid occurs until the new frame reaches (2,2).
- rst and pixel_in_valid asserted in the same cycle: rst wins and the pixel is dropped.

## Configuration
- WINDOW_OUT_REG_EN:
  - Defined: adds one output register stage on all nine taps, window_valid and frame_done. Latency becomes 2 cycles. The added registers reset to 0.
  - Undefined: latency is 1 cycle, as in Timing.
  - Window contents and ordering are identical in both builds.

## Test plan
- Reset: assert rst for 2 cycles with random pixel_in_valid -> all taps 0, window_valid=0, frame_done=0, and the first pixel after reset is treated as (0,0).
- Full frame (IMG_WIDTH=8, IMG_HEIGHT=6), pixel = {row, col, 8'hA5} (8 bits each), valid held high:
  - Exactly 24 window_valid pulses.
  - First pulse one cycle after accepting (2,2), with input_pixel_1=24'h0000A5, input_pixel_5=24'h0101A5, input_pixel_9=24'h0202A5.
  - No pulse on col 0/1 or row 0/1.
- Same frame with pixel_in_valid randomly low 40% of cycles -> identical sequence of 24 windows, and no pulses during gaps.
- Two back-to-back frames with the second frame's R channel offset by 8'h10 -> 24 correct windows per frame, and no stale first-frame data in any valid window. frame_done pulses exactly twice, each with the window centred on (4,6).
- rst asserted after 20 pixels (at (2,4)), then a full frame -> no window emitted from the aborted frame after reset, then exactly 24 correct windows.
- WINDOW_OUT_REG_EN defined, frame repeated -> same 24 windows, each appearing 2 cycles after its accepting edge.
